// File: rtl/commit_shadow_stack_monitor_if.sv
// Commit-port bundle for commit_shadow_stack_monitor, plus the shared types.
// The package carries the virtual-address width and the exception record that
// the commit stage merges into its own exception path.

package commit_shadow_stack_monitor_pkg;
    localparam int unsigned VLEN = 64;
    localparam int unsigned XLEN = 64;

    typedef logic [VLEN-1:0] vaddr_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;
endpackage

// Per-port retire information: master is the commit stage, slave the monitor.
interface commit_shadow_stack_monitor_if
    import commit_shadow_stack_monitor_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2
);
    logic   [NR_COMMIT_PORTS-1:0] commit_ack;
    logic   [NR_COMMIT_PORTS-1:0] is_call;
    logic   [NR_COMMIT_PORTS-1:0] is_ret;
    vaddr_t [NR_COMMIT_PORTS-1:0] link_addr;
    vaddr_t [NR_COMMIT_PORTS-1:0] ret_target;

    modport master (
        output commit_ack, is_call, is_ret, link_addr, ret_target
    );

    modport slave (
        input commit_ack, is_call, is_ret, link_addr, ret_target
    );
endinterface

// File: rtl/commit_shadow_stack_monitor.sv
// Commit-time shadow return-address stack. Calls retired on any commit port
// push their link address, returns pop and compare against the resolved
// target; a mismatch or a true underflow raises a registered CFI exception
// and freezes the stack until a flush. When full, pushes overwrite the oldest
// entry and bump a saturating "lost" count so the matching deep returns pass
// unchecked instead of faulting.
// Optional feature macro: CFI_STATS_EN (violation counter + overflow flag
// shown on leds_o).

module commit_shadow_stack_monitor
    import commit_shadow_stack_monitor_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned SS_DEPTH        = 16,
    parameter int unsigned CFI_CAUSE       = 24
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          en_i,
    commit_shadow_stack_monitor_if.slave  commit_if,
    output exception_t                    exception_o,
    output logic [9:0]                    leds_o
);

    localparam int unsigned PTR_W = $clog2(SS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SS_DEPTH);
    localparam logic [6:0]       LOST_MAX = 7'h7f;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ARMED,
        ST_TRAPPED
    } state_e;

    state_e                        r_state, w_state_nxt;
    vaddr_t [SS_DEPTH-1:0]         r_stack, w_stack_nxt;
    logic   [PTR_W-1:0]            r_tos,   w_tos_nxt;
    logic   [CNT_W-1:0]            r_count, w_count_nxt;
    logic   [6:0]                  r_lost,  w_lost_nxt;
    exception_t                    r_exc,   w_exc_nxt;
    logic                          w_viol;
`ifdef CFI_STATS_EN
    logic                          w_overflow;
    logic   [7:0]                  r_viol_cnt;
    logic                          r_ovf;
`endif

    // Next-state: mode transitions plus in-order walk over the commit ports.
    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_stack_nxt = r_stack;
        w_tos_nxt   = r_tos;
        w_count_nxt = r_count;
        w_lost_nxt  = r_lost;
        w_exc_nxt   = r_exc;
        w_viol      = 1'b0;
`ifdef CFI_STATS_EN
        w_overflow  = 1'b0;
`endif

        unique case (r_state)
            ST_OFF: begin
                // Commits in the enabling cycle are not checked.
                w_state_nxt = ST_ARMED;
            end

            ST_ARMED: begin
                if (flush_i) begin
                    w_tos_nxt   = '0;
                    w_count_nxt = '0;
                    w_lost_nxt  = '0;
                end else begin
                    // Blocking updates chain through the ports: port i sees
                    // the stack left behind by ports 0..i-1.
                    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                        if (!w_viol && commit_if.commit_ack[i]) begin
                            if (commit_if.is_ret[i]) begin
                                if (w_count_nxt != '0) begin
                                    w_tos_nxt   = w_tos_nxt - PTR_ONE;
                                    w_count_nxt = w_count_nxt - CNT_ONE;
                                    if (w_stack_nxt[w_tos_nxt] != commit_if.ret_target[i])
                                        w_viol = 1'b1;
                                end else if (w_lost_nxt != '0) begin
                                    w_lost_nxt = w_lost_nxt - 7'd1;
                                end else begin
                                    w_viol = 1'b1;
                                end
                                if (w_viol) begin
                                    w_exc_nxt.valid = 1'b1;
                                    w_exc_nxt.cause = XLEN'(CFI_CAUSE);
                                    w_exc_nxt.tval  = XLEN'(commit_if.ret_target[i]);
                                    w_state_nxt     = ST_TRAPPED;
                                end
                            end
                            // Co-routine swap: the pop above happens before this push.
                            if (!w_viol && commit_if.is_call[i]) begin
                                w_stack_nxt[w_tos_nxt] = commit_if.link_addr[i];
                                w_tos_nxt              = w_tos_nxt + PTR_ONE;
                                if (w_count_nxt == CNT_FULL) begin
                                    if (w_lost_nxt != LOST_MAX)
                                        w_lost_nxt = w_lost_nxt + 7'd1;
`ifdef CFI_STATS_EN
                                    w_overflow = 1'b1;
`endif
                                end else begin
                                    w_count_nxt = w_count_nxt + CNT_ONE;
                                end
                            end
                        end
                    end
                end
            end

            ST_TRAPPED: begin
                // Stack frozen; only a flush releases the trap.
                if (flush_i) begin
                    w_state_nxt = ST_ARMED;
                    w_tos_nxt   = '0;
                    w_count_nxt = '0;
                    w_lost_nxt  = '0;
                    w_exc_nxt   = '0;
                end
            end

            default: w_state_nxt = ST_OFF;
        endcase

        // Disable dominates everything, including a same-cycle violation.
        if (!en_i) begin
            w_state_nxt = ST_OFF;
            w_tos_nxt   = '0;
            w_count_nxt = '0;
            w_lost_nxt  = '0;
            w_exc_nxt   = '0;
            w_viol      = 1'b0;
`ifdef CFI_STATS_EN
            w_overflow  = 1'b0;
`endif
        end
    end

    // Control registers: mode, pointers, counts and the registered exception.
    // NOTE: state registers use non-blocking assignment; the blocking ones above are combinational scratch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_OFF;
            r_tos   <= '0;
            r_count <= '0;
            r_lost  <= '0;
            r_exc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tos   <= w_tos_nxt;
            r_count <= w_count_nxt;
            r_lost  <= w_lost_nxt;
            r_exc   <= w_exc_nxt;
        end
    end

    // Stack storage.
    // NOTE: the entries are not reset; r_count says which of them are valid.
    always_ff @(posedge clk_i) begin
        r_stack <= w_stack_nxt;
    end

    assign exception_o = r_exc;

`ifdef CFI_STATS_EN
    // Statistics: saturating trap count and sticky overflow flag, reset-only clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_viol_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_viol && r_viol_cnt != 8'hff)
                r_viol_cnt <= r_viol_cnt + 8'd1;
            if (w_overflow)
                r_ovf <= 1'b1;
        end
    end

    // Status LEDs: overflow seen, trapped, violation count.
    always_comb begin
        leds_o = {r_ovf, r_state == ST_TRAPPED, r_viol_cnt};
    end
`else
    // Status LEDs: trapped and armed indicators only.
    always_comb begin
        leds_o = {8'b0, r_state == ST_TRAPPED, r_state == ST_ARMED};
    end
`endif

endmodule

// File: tb/tb_commit_shadow_stack_monitor.sv
// Scoreboard bench for commit_shadow_stack_monitor (2 ports, depth 4).
// The driver advances a queue-based reference model and pushes the expected
// post-edge outputs; a monitor pops and compares them on the falling edge.

module tb_commit_shadow_stack_monitor;
    import commit_shadow_stack_monitor_pkg::*;

    localparam int NP    = 2;
    localparam int DEPTH = 4;
    localparam int CAUSE = 24;

    localparam int M_OFF  = 0;
    localparam int M_ARM  = 1;
    localparam int M_TRAP = 2;

    typedef struct {
        logic        valid;
        logic [63:0] cause;
        logic [63:0] tval;
        logic [9:0]  leds;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       en_i;
    exception_t exception_o;
    logic [9:0] leds_o;

    commit_shadow_stack_monitor_if #(.NR_COMMIT_PORTS(NP)) cif ();

    commit_shadow_stack_monitor #(
        .NR_COMMIT_PORTS (NP),
        .SS_DEPTH        (DEPTH),
        .CFI_CAUSE       (CAUSE)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .en_i        (en_i),
        .commit_if   (cif),
        .exception_o (exception_o),
        .leds_o      (leds_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // Reference model state
    int          m_state = M_OFF;
    vaddr_t      m_stack[$];
    int          m_lost  = 0;
    logic        m_valid = 1'b0;
    logic [63:0] m_cause = '0;
    logic [63:0] m_tval  = '0;
    int          m_vcnt  = 0;
    bit          m_ovf   = 1'b0;

    vaddr_t s_link[NP];
    vaddr_t s_tgt[NP];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_leds();
`ifdef CFI_STATS_EN
        return {m_ovf, m_state == M_TRAP, 8'(m_vcnt)};
`else
        return {8'b0, m_state == M_TRAP, m_state == M_ARM};
`endif
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.valid = m_valid;
        e.cause = m_cause;
        e.tval  = m_tval;
        e.leds  = model_leds();
        return e;
    endfunction

    task automatic model_reset();
        m_state = M_OFF;
        m_stack.delete();
        m_lost  = 0;
        m_valid = 1'b0;
        m_cause = '0;
        m_tval  = '0;
        m_vcnt  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit flush,
                              input bit [NP-1:0] ack, input bit [NP-1:0] call,
                              input bit [NP-1:0] ret);
        bit bad;
        if (!en) begin
            m_state = M_OFF;
            m_stack.delete();
            m_lost  = 0;
            m_valid = 1'b0;
        end else if (m_state == M_OFF) begin
            m_state = M_ARM;
        end else if (flush) begin
            m_state = M_ARM;
            m_stack.delete();
            m_lost  = 0;
            m_valid = 1'b0;
        end else if (m_state == M_ARM) begin
            for (int i = 0; i < NP; i++) begin
                bad = 1'b0;
                if (!ack[i]) continue;
                if (ret[i]) begin
                    if (m_stack.size() > 0) begin
                        if (m_stack.pop_back() != s_tgt[i]) bad = 1'b1;
                    end else if (m_lost > 0) begin
                        m_lost--;
                    end else begin
                        bad = 1'b1;
                    end
                end
                if (bad) begin
                    m_valid = 1'b1;
                    m_cause = 64'(CAUSE);
                    m_tval  = s_tgt[i];
                    m_state = M_TRAP;
                    if (m_vcnt < 255) m_vcnt++;
                    break;
                end
                if (call[i]) begin
                    m_stack.push_back(s_link[i]);
                    if (m_stack.size() > DEPTH) begin
                        void'(m_stack.pop_front());
                        if (m_lost < 127) m_lost++;
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic addr(input vaddr_t l0, input vaddr_t l1, input vaddr_t t0, input vaddr_t t1);
        s_link[0] = l0; s_link[1] = l1;
        s_tgt[0]  = t0; s_tgt[1]  = t1;
    endtask

    // One clock of stimulus: drive, step the model, push the post-edge expectation.
    task automatic cyc(input bit en, input bit flush,
                       input bit [NP-1:0] ack, input bit [NP-1:0] call, input bit [NP-1:0] ret);
        en_i           = en;
        flush_i        = flush;
        cif.commit_ack = ack;
        cif.is_call    = call;
        cif.is_ret     = ret;
        for (int i = 0; i < NP; i++) begin
            cif.link_addr[i]  = s_link[i];
            cif.ret_target[i] = s_tgt[i];
        end
        model_step(en, flush, ack, call, ret);
        @(posedge clk_i);
        exp_q.push_back(snapshot());
        #2;
    endtask

    task automatic idle(input bit en, input int n);
        for (int k = 0; k < n; k++) cyc(en, 1'b0, '0, '0, '0);
    endtask

    // Monitor: every falling edge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("exc_valid", 64'(exception_o.valid), 64'(e.valid));
                if (e.valid) begin
                    check("exc_cause", exception_o.cause, e.cause);
                    check("exc_tval", exception_o.tval, e.tval);
                end
                check("leds", 64'(leds_o), 64'(e.leds));
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni         = 1'b0;
        en_i           = 1'b0;
        flush_i        = 1'b0;
        cif.commit_ack = '0;
        cif.is_call    = '0;
        cif.is_ret     = '0;
        cif.link_addr  = '0;
        cif.ret_target = '0;
        addr(0, 0, 0, 0);
        model_reset();
        #1;
        check("rst_cause", exception_o.cause, 64'h0);
        check("rst_tval", exception_o.tval, 64'h0);
        exp_q.push_back(snapshot());
        repeat (3) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;

        // Enabling cycle: a bogus return is ignored.
        addr(0, 0, 64'hdead, 0);
        cyc(1, 0, 2'b01, 2'b00, 2'b01);

        // Matched call/return
        addr(64'h8000_0104, 0, 0, 0);          cyc(1, 0, 2'b01, 2'b01, 2'b00);
        addr(0, 0, 64'h8000_0104, 0);          cyc(1, 0, 2'b01, 2'b00, 2'b01);
        idle(1, 1);

        // Mismatched return, held until flush
        addr(64'h1004, 0, 0, 0);               cyc(1, 0, 2'b01, 2'b01, 2'b00);
        addr(0, 0, 64'h2000, 0);               cyc(1, 0, 2'b01, 2'b00, 2'b01);
        addr(64'h3000, 0, 64'h3000, 0);        cyc(1, 0, 2'b01, 2'b01, 2'b01);
        idle(1, 1);
        cyc(1, 1, 2'b00, 2'b00, 2'b00);
        idle(1, 1);

        // Same-cycle push then pop
        addr(64'h40, 0, 0, 64'h40);            cyc(1, 0, 2'b11, 2'b01, 2'b10);
        idle(1, 1);

        // Lower port wins; port1 push suppressed
        addr(64'h500, 0, 0, 0);                cyc(1, 0, 2'b01, 2'b01, 2'b00);
        addr(0, 64'h600, 64'h999, 0);          cyc(1, 0, 2'b11, 2'b10, 2'b01);
        idle(1, 1);
        cyc(1, 1, 2'b00, 2'b00, 2'b00);

        // Overflow then underflow
        for (int k = 0; k < 6; k++) begin
            addr(64'hA0 + 64'(k), 0, 0, 0);    cyc(1, 0, 2'b01, 2'b01, 2'b00);
        end
        for (int k = 5; k >= 2; k--) begin
            addr(0, 0, 64'hA0 + 64'(k), 0);    cyc(1, 0, 2'b01, 2'b00, 2'b01);
        end
        addr(0, 0, 64'h123, 64'h456);          cyc(1, 0, 2'b11, 2'b00, 2'b11);
        addr(0, 0, 64'h777, 0);                cyc(1, 0, 2'b01, 2'b00, 2'b01);
        idle(1, 1);
        cyc(1, 1, 2'b00, 2'b00, 2'b00);

        // Violation coinciding with flush: flush wins
        addr(64'h10, 0, 0, 0);                 cyc(1, 0, 2'b01, 2'b01, 2'b00);
        addr(0, 0, 64'h20, 0);                 cyc(1, 1, 2'b01, 2'b00, 2'b01);
        idle(1, 1);

        // Enable dropped while trapped
        addr(0, 0, 64'h30, 0);                 cyc(1, 0, 2'b01, 2'b00, 2'b01);
        idle(1, 1);
        idle(0, 2);
        idle(1, 1);

        // Randomized traffic from a small address pool
        for (int n = 0; n < 400; n++) begin
            bit [NP-1:0] ack, call, ret;
            for (int i = 0; i < NP; i++) begin
                ack[i]    = ($urandom_range(0, 3) != 0);
                call[i]   = ($urandom_range(0, 4) < 2);
                ret[i]    = ($urandom_range(0, 4) < 2);
                s_link[i] = 64'h1000 + 64'(4 * $urandom_range(0, 3));
                s_tgt[i]  = 64'h1000 + 64'(4 * $urandom_range(0, 3));
            end
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0), ack, call, ret);
        end

        // Asynchronous reset while trapped
        idle(0, 1);
        idle(1, 1);
        addr(0, 0, 64'h55, 0);                 cyc(1, 0, 2'b01, 2'b00, 2'b01);
        idle(1, 1);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 64'(exception_o.valid), 64'h0);
        check("arst_cause", exception_o.cause, 64'h0);
        check("arst_tval", exception_o.tval, 64'h0);
        check("arst_leds", 64'(leds_o), 64'h0);
        model_reset();
        en_i           = 1'b0;
        cif.commit_ack = '0;
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;

        // Back to normal operation after reset
        idle(1, 1);
        addr(64'h9000, 0, 0, 64'h9000);        cyc(1, 0, 2'b11, 2'b01, 2'b10);
        addr(0, 0, 64'h9004, 0);               cyc(1, 0, 2'b01, 2'b00, 2'b01);
        idle(1, 2);

        @(negedge clk_i);
        #1;
        check("drain", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
